// File: rtl/decode_control_stage_if.sv
// Shared decode types and the IF/ID -> EX bundle around the decode/control stage.
// The type package lives here so the interface and the stage see one definition.
package decode_types_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_t;

   typedef enum logic [3:0] {
      addALU  = 4'd0,
      subALU  = 4'd1,
      sllALU  = 4'd2,
      sltALU  = 4'd3,
      sltuALU = 4'd4,
      xorALU  = 4'd5,
      srlALU  = 4'd6,
      sraALU  = 4'd7,
      orALU   = 4'd8,
      andALU  = 4'd9,
      luiALU  = 4'd10
   } ALU_operation_t;

endpackage

interface decode_control_stage_if;
   import decode_types_pkg::*;

   logic [31:0]    instructionCode;
   logic           validIn;
   logic           stall;
   logic           flush;

   logic           validOut;
   logic [6:0]     opcode;
   logic [6:0]     funct7;
   logic [2:0]     funct3;
   logic [4:0]     rs1;
   logic [4:0]     rs2;
   logic [4:0]     rd;
   logic [31:0]    immediate;
   logic           useImmediate;
   logic           readMemory;
   logic           writeMemory;
   logic           writeRegister;
   logic [1:0]     writebackItem;
   logic           branch;
   logic           pcInputA;
   ALU_operation_t operationALU;
   logic           illegal;

   modport master (
      output instructionCode, validIn, stall, flush,
      input  validOut, opcode, funct7, funct3, rs1, rs2, rd, immediate,
             useImmediate, readMemory, writeMemory, writeRegister,
             writebackItem, branch, pcInputA, operationALU, illegal
   );

   modport slave (
      input  instructionCode, validIn, stall, flush,
      output validOut, opcode, funct7, funct3, rs1, rs2, rd, immediate,
             useImmediate, readMemory, writeMemory, writeRegister,
             writebackItem, branch, pcInputA, operationALU, illegal
   );

endinterface

// File: rtl/decode_control_stage.sv
// RV32I decoder and main control unit; every result is registered for the EX stage.
// Priority on each edge: rst, then flush, then stall, then load.
module decode_control_stage
   import decode_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   decode_control_stage_if.slave bus
);

   logic [31:0]    instr;
   logic [6:0]     opc;
   logic [2:0]     f3;
   logic [6:0]     f7;

   logic [XLEN-1:0] imm_d, imm_q;
   logic           use_imm_d, use_imm_q;
   logic           rd_mem_d, rd_mem_q;
   logic           wr_mem_d, wr_mem_q;
   logic           wr_reg_d, wr_reg_q;
   logic [1:0]     wb_d, wb_q;
   logic           branch_d, branch_q;
   logic           pc_a_d, pc_a_q;
   ALU_operation_t alu_d, alu_q;
   logic           illegal_d, illegal_q;
   logic           valid_q;
   logic [6:0]     opcode_q, funct7_q;
   logic [2:0]     funct3_q;
   logic [4:0]     rs1_q, rs2_q, rd_q;

   assign instr = bus.instructionCode;
   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];

   // allow_sub is cleared for OP-IMM, where funct7[5] on funct3=000 is immediate data
   function automatic ALU_operation_t alu_decode(input logic [2:0] fn3, input logic alt,
                                                 input logic allow_sub);
      ALU_operation_t op;
      op = addALU;
      case (fn3)
         3'b000: op = (alt && allow_sub) ? subALU : addALU;
         3'b001: op = sllALU;
         3'b010: op = sltALU;
         3'b011: op = sltuALU;
         3'b100: op = xorALU;
         3'b101: op = alt ? sraALU : srlALU;
         3'b110: op = orALU;
         3'b111: op = andALU;
         default: op = addALU;
      endcase
      return op;
   endfunction

   always_comb begin
      imm_d     = '0;
      use_imm_d = 1'b0;
      rd_mem_d  = 1'b0;
      wr_mem_d  = 1'b0;
      wr_reg_d  = 1'b0;
      wb_d      = 2'd0;
      branch_d  = 1'b0;
      pc_a_d    = 1'b0;
      alu_d     = addALU;
      illegal_d = 1'b0;
      case (opc)
         OPC_OP: begin
            wr_reg_d = 1'b1;
            alu_d    = alu_decode(f3, f7[5], 1'b1);
         end
         OPC_OP_IMM: begin
            imm_d     = {{20{instr[31]}}, instr[31:20]};
            use_imm_d = 1'b1;
            wr_reg_d  = 1'b1;
            alu_d     = alu_decode(f3, f7[5], 1'b0);
         end
         OPC_LOAD: begin
            imm_d     = {{20{instr[31]}}, instr[31:20]};
            use_imm_d = 1'b1;
            rd_mem_d  = 1'b1;
            wr_reg_d  = 1'b1;
            wb_d      = 2'd1;
         end
         OPC_STORE: begin
            imm_d     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            use_imm_d = 1'b1;
            wr_mem_d  = 1'b1;
         end
         OPC_BRANCH: begin
            imm_d    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            branch_d = 1'b1;
            case (f3[2:1])
               2'b00:   alu_d = subALU;
               2'b10:   alu_d = sltALU;
               2'b11:   alu_d = sltuALU;
               default: alu_d = addALU;
            endcase
         end
         OPC_JAL: begin
            imm_d     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            use_imm_d = 1'b1;
            wr_reg_d  = 1'b1;
            wb_d      = 2'd2;
            branch_d  = 1'b1;
            pc_a_d    = 1'b1;
         end
         OPC_JALR: begin
            imm_d     = {{20{instr[31]}}, instr[31:20]};
            use_imm_d = 1'b1;
            wr_reg_d  = 1'b1;
            wb_d      = 2'd2;
            branch_d  = 1'b1;
         end
         OPC_LUI: begin
            imm_d     = {instr[31:12], 12'b0};
            use_imm_d = 1'b1;
            wr_reg_d  = 1'b1;
            alu_d     = luiALU;
         end
         OPC_AUIPC: begin
            imm_d     = {instr[31:12], 12'b0};
            use_imm_d = 1'b1;
            wr_reg_d  = 1'b1;
         end
         default: illegal_d = 1'b1;
      endcase
      // A bubble must never have architectural side effects
      if (!bus.validIn) begin
         rd_mem_d  = 1'b0;
         wr_mem_d  = 1'b0;
         wr_reg_d  = 1'b0;
         branch_d  = 1'b0;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         funct7_q  <= '0;
         funct3_q  <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         rd_mem_q  <= 1'b0;
         wr_mem_q  <= 1'b0;
         wr_reg_q  <= 1'b0;
         wb_q      <= 2'd0;
         branch_q  <= 1'b0;
         pc_a_q    <= 1'b0;
         alu_q     <= addALU;
         illegal_q <= 1'b0;
      end else if (!bus.stall) begin
         valid_q   <= bus.validIn;
         opcode_q  <= opc;
         funct7_q  <= f7;
         funct3_q  <= f3;
         rs1_q     <= instr[19:15];
         rs2_q     <= instr[24:20];
         rd_q      <= instr[11:7];
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         rd_mem_q  <= rd_mem_d;
         wr_mem_q  <= wr_mem_d;
         wr_reg_q  <= wr_reg_d;
         wb_q      <= wb_d;
         branch_q  <= branch_d;
         pc_a_q    <= pc_a_d;
         alu_q     <= alu_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.validOut      = valid_q;
   assign bus.opcode        = opcode_q;
   assign bus.funct7        = funct7_q;
   assign bus.funct3        = funct3_q;
   assign bus.rs1           = rs1_q;
   assign bus.rs2           = rs2_q;
   assign bus.rd            = rd_q;
   assign bus.immediate     = imm_q;
   assign bus.useImmediate  = use_imm_q;
   assign bus.readMemory    = rd_mem_q;
   assign bus.writeMemory   = wr_mem_q;
   assign bus.writeRegister = wr_reg_q;
   assign bus.writebackItem = wb_q;
   assign bus.branch        = branch_q;
   assign bus.pcInputA      = pc_a_q;
   assign bus.operationALU  = alu_q;
   assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: hand-decoded RV32I vectors plus
// reset, stall, flush and bubble behaviour.
module tb_decode_control_stage;
   import decode_types_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   decode_control_stage_if bus ();

   decode_control_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   // ctrl packs {useImm, rdMem, wrMem, wrReg, wb[1:0], branch, pcA}
   task automatic chk_out(input string t, input logic [7:0] ctrl, input logic [31:0] imm,
                          input ALU_operation_t alu, input logic ill, input logic vo);
      chk({t, ".ctrl"}, {24'd0, bus.useImmediate, bus.readMemory, bus.writeMemory,
                         bus.writeRegister, bus.writebackItem, bus.branch, bus.pcInputA},
          {24'd0, ctrl});
      chk({t, ".imm"}, bus.immediate, imm);
      chk({t, ".alu"}, {28'd0, bus.operationALU}, {28'd0, alu});
      chk({t, ".illegal"}, {31'd0, bus.illegal}, {31'd0, ill});
      chk({t, ".validOut"}, {31'd0, bus.validOut}, {31'd0, vo});
   endtask

   task automatic step(input logic [31:0] ins, input logic vi, input logic st, input logic fl);
      bus.instructionCode = ins;
      bus.validIn         = vi;
      bus.stall           = st;
      bus.flush           = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.instructionCode = 32'h0020_81b3;
      bus.validIn         = 1'b1;
      bus.stall           = 1'b0;
      bus.flush           = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_out("reset", 8'h00, 32'h0, addALU, 1'b0, 1'b0);
      chk("reset.opcode", {25'd0, bus.opcode}, 32'h0);
      chk("reset.rd", {27'd0, bus.rd}, 32'h0);
      rst = 1'b0;

      step(32'h0020_81b3, 1'b1, 1'b0, 1'b0);
      chk_out("add", 8'h10, 32'h0, addALU, 1'b0, 1'b1);
      chk("add.rd", {27'd0, bus.rd}, 32'd3);
      chk("add.rs1", {27'd0, bus.rs1}, 32'd1);
      chk("add.rs2", {27'd0, bus.rs2}, 32'd2);
      chk("add.opcode", {25'd0, bus.opcode}, 32'h33);

      step(32'h4020_8133, 1'b1, 1'b0, 1'b0);
      chk_out("sub", 8'h10, 32'h0, subALU, 1'b0, 1'b1);
      chk("sub.funct7", {25'd0, bus.funct7}, 32'h20);

      step(32'h0050_8113, 1'b1, 1'b0, 1'b0);
      chk_out("addi", 8'h90, 32'd5, addALU, 1'b0, 1'b1);
      chk("addi.rd", {27'd0, bus.rd}, 32'd2);

      step(32'h4030_d093, 1'b1, 1'b0, 1'b0);
      chk_out("srai", 8'h90, 32'd1027, sraALU, 1'b0, 1'b1);
      chk("srai.funct3", {29'd0, bus.funct3}, 32'd5);

      step(32'h0100_a103, 1'b1, 1'b0, 1'b0);
      chk_out("lw", 8'hD4, 32'd16, addALU, 1'b0, 1'b1);

      step(32'h0020_a823, 1'b1, 1'b0, 1'b0);
      chk_out("sw", 8'hA0, 32'd16, addALU, 1'b0, 1'b1);

      step(32'hFE20_86E3, 1'b1, 1'b0, 1'b0);
      chk_out("beq", 8'h02, 32'hFFFF_FFEC, subALU, 1'b0, 1'b1);

      step(32'hFE20_C6E3, 1'b1, 1'b0, 1'b0);
      chk_out("blt", 8'h02, 32'hFFFF_FFEC, sltALU, 1'b0, 1'b1);

      step(32'h0200_00ef, 1'b1, 1'b0, 1'b0);
      chk_out("jal", 8'h9B, 32'd32, addALU, 1'b0, 1'b1);
      chk("jal.rd", {27'd0, bus.rd}, 32'd1);

      step(32'h0101_00e7, 1'b1, 1'b0, 1'b0);
      chk_out("jalr", 8'h9A, 32'd16, addALU, 1'b0, 1'b1);

      step(32'h1234_50b7, 1'b1, 1'b0, 1'b0);
      chk_out("lui", 8'h90, 32'h1234_5000, luiALU, 1'b0, 1'b1);

      step(32'h1234_5097, 1'b1, 1'b0, 1'b0);
      chk_out("auipc", 8'h90, 32'h1234_5000, addALU, 1'b0, 1'b1);

      step(32'h0020_81b3, 1'b1, 1'b1, 1'b0);
      chk_out("stall", 8'h90, 32'h1234_5000, addALU, 1'b0, 1'b1);
      chk("stall.opcode", {25'd0, bus.opcode}, 32'h17);

      step(32'h0100_a103, 1'b1, 1'b1, 1'b1);
      chk_out("flush_stall", 8'h00, 32'h0, addALU, 1'b0, 1'b0);
      chk("flush_stall.rd", {27'd0, bus.rd}, 32'h0);

      step(32'h0020_a823, 1'b0, 1'b0, 1'b0);
      chk_out("bubble_sw", 8'h80, 32'd16, addALU, 1'b0, 1'b0);
      chk("bubble_sw.writeMemory", {31'd0, bus.writeMemory}, 32'h0);

      step(32'h0000_007f, 1'b1, 1'b0, 1'b0);
      chk_out("illegal", 8'h00, 32'h0, addALU, 1'b1, 1'b1);
      chk("illegal.opcode", {25'd0, bus.opcode}, 32'h7f);

      step(32'h0000_007f, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step(32'h0020_81b3, 1'b1, 1'b0, 1'b0);
      chk_out("rst_again", 8'h00, 32'h0, addALU, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
